regfile_mp: RTL and testbench

//   Parametrised multi-read-port integer register file for the pipelined RISC-V core.

---
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_mp.sv | 159 +++++++++++++++
 tb/tb_regfile_mp.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module      : regfile_mp_if
// Description : Write/read bus bundle for the multi-port register file.
//               The master drives the write request and the read addresses.
//               The slave (the register file) returns the read data, the
//               clear-sequencer status and the debug a0 view.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic [2:0]                     we_mode;
    logic [ADDR_WIDTH-1:0]          wa;
    logic [DATA_WIDTH-1:0]          wd;
    logic [NUM_READ*ADDR_WIDTH-1:0] ra;
    logic [NUM_READ*DATA_WIDTH-1:0] rd;
    logic                           init_busy;
    logic [DATA_WIDTH-1:0]          a0;

    modport master (
        output we_mode, wa, wd, ra,
        input  rd, init_busy, a0
    );

    modport slave (
        input  we_mode, wa, wd, ra,
        output rd, init_busy, a0
    );
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised integer register file with NUM_READ combinational
//               read ports, one write port with load-extension modes, hardwired
//               x0, same-cycle write-to-read bypass and a reset-driven clear
//               sequencer that zeroes one register per cycle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int DBG_INDEX  = 10
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    regfile_mp_if.slave     bus
);

    localparam int                    DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] c_DBG  = ADDR_WIDTH'(DBG_INDEX);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [2:0]              w_mode;
    logic [ADDR_WIDTH-1:0]   w_wa;
    logic [DATA_WIDTH-1:0]   w_wd;
    logic                    w_run;
    logic                    w_mode_wr;
    logic                    w_byp;
    logic [DATA_WIDTH-1:0]   w_ext;

    assign w_mode = bus.we_mode;
    assign w_wa   = bus.wa;
    assign w_wd   = bus.wd;
    assign w_run  = (state_q == ST_RUN);

    // Sequencer state and clear counter; reset restarts the clear from x0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Walk the clear index across the whole array, then hand over to RUN.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_INIT) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == c_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    // Decode write mode and build the extended write value.
    always_comb begin
        w_mode_wr = 1'b0;
        w_ext     = w_wd;
        case (w_mode)
            3'b001: begin
                w_mode_wr = 1'b1;
                w_ext     = w_wd;
            end
            3'b010: begin
                w_mode_wr = 1'b1;
                w_ext     = DATA_WIDTH'($signed(w_wd[15:0]));
            end
            3'b011: begin
                w_mode_wr = 1'b1;
                w_ext     = DATA_WIDTH'($signed(w_wd[7:0]));
            end
            3'b110: begin
                w_mode_wr = 1'b1;
                w_ext     = DATA_WIDTH'(w_wd[15:0]);
            end
            3'b111: begin
                w_mode_wr = 1'b1;
                w_ext     = DATA_WIDTH'(w_wd[7:0]);
            end
            default: begin
                w_mode_wr = 1'b0;
                w_ext     = w_wd;
            end
        endcase
    end

    // A user write is live in RUN to any register but x0; it also feeds the bypass.
    assign w_byp = w_run && w_mode_wr && (w_wa != '0);

    // Array update: clearing during INIT, user writes in RUN; reset drops both.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                mem_q[clr_idx_q] <= '0;
            end else if (w_byp) begin
                mem_q[w_wa] <= w_ext;
            end
        end
    end

    // Shared read rule: zero in INIT and for x0, bypass a matching write, else array.
    function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] addr);
        if (!w_run || (addr == '0)) begin
            return '0;
        end else if (w_byp && (w_wa == addr)) begin
            return w_ext;
        end else begin
            return mem_q[addr];
        end
    endfunction

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_rd;

        assign w_ra = bus.ra[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Independent combinational read for port k.
        always_comb begin
            w_rd = f_read(w_ra);
        end

        assign bus.rd[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    end

    if (DBG_INDEX == 0) begin : g_a0_zero
        assign bus.a0 = '0;
    end else begin : g_a0_reg
        logic [DATA_WIDTH-1:0] w_a0;

        // Debug view of the ABI a0 register, following the same bypass rule.
        always_comb begin
            w_a0 = f_read(c_DBG);
        end

        assign bus.a0 = w_a0;
    end

    assign bus.init_busy = (state_q == ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Two instances: the default
//               configuration and a 3-read-port, 16-entry configuration.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;

    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) ifa ();
    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_READ(3)) ifb ();

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .DBG_INDEX(10)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (ifa)
    );

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_READ(3), .DBG_INDEX(10)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register contents plus cycles of clearing still to go.
    logic [31:0] ma [32];
    logic [31:0] mb [16];
    int          busy_a = 32;
    int          busy_b = 16;

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] wd;
        logic [31:0] exp;
    } mode_vec_t;

    mode_vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic bit is_wr(input logic [2:0] m);
        return (m == 3'd1) || (m == 3'd2) || (m == 3'd3) || (m == 3'd6) || (m == 3'd7);
    endfunction

    // Load extension by arithmetic on the low byte / halfword value.
    function automatic logic [31:0] ext(input logic [2:0] m, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = d & 32'h0000_00FF;
        h = d & 32'h0000_FFFF;
        case (m)
            3'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd3:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd6:    return h;
            3'd7:    return b;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_a(input logic [4:0] addr, input logic [2:0] m,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (busy_a > 0 || addr == 5'd0) return 32'd0;
        if (is_wr(m) && wa == addr) return ext(m, wd);
        return ma[addr];
    endfunction

    function automatic logic [31:0] exp_b(input logic [3:0] addr, input logic [2:0] m,
                                          input logic [3:0] wa, input logic [31:0] wd);
        if (busy_b > 0 || addr == 4'd0) return 32'd0;
        if (is_wr(m) && wa == addr) return ext(m, wd);
        return mb[addr];
    endfunction

    // One cycle on instance A: drive, check before the edge, advance model.
    task automatic run_a(input logic rstn, input logic [2:0] m, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1,
                         output logic [31:0] g0);
        rst_n_a     = rstn;
        ifa.we_mode = m;
        ifa.wa      = wa;
        ifa.wd      = wd;
        ifa.ra      = {r1, r0};
        @(negedge clk);
        g0 = ifa.rd[31:0];
        chk("a.rd0",  ifa.rd[31:0],  exp_a(r0, m, wa, wd));
        chk("a.rd1",  ifa.rd[63:32], exp_a(r1, m, wa, wd));
        chk("a.a0",   ifa.a0,        exp_a(5'd10, m, wa, wd));
        chk("a.busy", {31'd0, ifa.init_busy}, (busy_a > 0) ? 32'd1 : 32'd0);
        @(posedge clk);
        if (!rstn) begin
            busy_a = 32;
        end else if (busy_a > 0) begin
            busy_a--;
            if (busy_a == 0) foreach (ma[i]) ma[i] = 32'd0;
        end else if (is_wr(m) && wa != 5'd0) begin
            ma[wa] = ext(m, wd);
        end
        #1;
    endtask

    task automatic run_b(input logic rstn, input logic [2:0] m, input logic [3:0] wa,
                         input logic [31:0] wd, input logic [3:0] r0, input logic [3:0] r1,
                         input logic [3:0] r2);
        rst_n_b     = rstn;
        ifb.we_mode = m;
        ifb.wa      = wa;
        ifb.wd      = wd;
        ifb.ra      = {r2, r1, r0};
        @(negedge clk);
        chk("b.rd0",  ifb.rd[31:0],  exp_b(r0, m, wa, wd));
        chk("b.rd1",  ifb.rd[63:32], exp_b(r1, m, wa, wd));
        chk("b.rd2",  ifb.rd[95:64], exp_b(r2, m, wa, wd));
        chk("b.a0",   ifb.a0,        exp_b(4'd10, m, wa, wd));
        chk("b.busy", {31'd0, ifb.init_busy}, (busy_b > 0) ? 32'd1 : 32'd0);
        @(posedge clk);
        if (!rstn) begin
            busy_b = 16;
        end else if (busy_b > 0) begin
            busy_b--;
            if (busy_b == 0) foreach (mb[i]) mb[i] = 32'd0;
        end else if (is_wr(m) && wa != 4'd0) begin
            mb[wa] = ext(m, wd);
        end
        #1;
    endtask

    // Count cycles until init_busy drops on A, optionally firing writes that must be lost.
    task automatic wait_init_a(input logic [2:0] m, output int cnt);
        logic [31:0] g;
        cnt = 0;
        while (ifa.init_busy && cnt < 100) begin
            run_a(1'b1, m, 5'd9, 32'h0000_0055, 5'd9, 5'd5, g);
            cnt++;
        end
    endtask

    initial begin
        logic [31:0] g;
        int          cnt;

        tbl[0] = '{3'b001, 32'h8000_F0F0, 32'h8000_F0F0};
        tbl[1] = '{3'b011, 32'h0000_0085, 32'hFFFF_FF85};
        tbl[2] = '{3'b111, 32'h0000_0085, 32'h0000_0085};
        tbl[3] = '{3'b010, 32'h0000_9234, 32'hFFFF_9234};
        tbl[4] = '{3'b110, 32'h0000_9234, 32'h0000_9234};
        tbl[5] = '{3'b100, 32'h1111_1111, 32'h0000_9234};
        tbl[6] = '{3'b101, 32'h2222_2222, 32'h0000_9234};
        tbl[7] = '{3'b000, 32'h3333_3333, 32'h0000_9234};

        foreach (ma[i]) ma[i] = 32'd0;
        foreach (mb[i]) mb[i] = 32'd0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        ifa.we_mode = 3'd0; ifa.wa = '0; ifa.wd = '0; ifa.ra = '0;
        ifb.we_mode = 3'd0; ifb.wa = '0; ifb.wd = '0; ifb.ra = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then first clear sequence.
        run_a(1'b0, 3'd1, 5'd3, 32'h1234_5678, 5'd3, 5'd10, g);
        wait_init_a(3'd0, cnt);
        chk("init_len_first", cnt, 32);

        // Reset clear of a preloaded register.
        run_a(1'b1, 3'd1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, g);
        run_a(1'b1, 3'd0, 5'd0, 32'd0, 5'd5, 5'd5, g);
        chk("x5_preload", g, 32'hDEAD_BEEF);
        run_a(1'b0, 3'd0, 5'd0, 32'd0, 5'd5, 5'd5, g);
        wait_init_a(3'd0, cnt);
        chk("init_len", cnt, 32);
        run_a(1'b1, 3'd0, 5'd0, 32'd0, 5'd5, 5'd5, g);
        chk("x5_cleared", g, 32'h0000_0000);

        // Write modes into x6, table-driven.
        for (int i = 0; i < 8; i++) begin
            run_a(1'b1, tbl[i].mode, 5'd6, tbl[i].wd, 5'd1, 5'd6, g);
            run_a(1'b1, 3'd0, 5'd0, 32'd0, 5'd6, 5'd6, g);
            chk($sformatf("mode_%0d", i), g, tbl[i].exp);
        end

        // x0 stays zero, including in the write cycle.
        run_a(1'b1, 3'd1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, g);
        chk("x0_wcycle", g, 32'd0);
        run_a(1'b1, 3'd0, 5'd0, 32'd0, 5'd0, 5'd0, g);
        chk("x0_after", g, 32'd0);

        // Bypass on both ports and a0.
        run_a(1'b1, 3'd1, 5'd10, 32'hCAFE_0001, 5'd10, 5'd10, g);
        chk("bypass", g, 32'hCAFE_0001);
        chk("bypass_a0", ifa.a0, 32'hCAFE_0001);
        run_a(1'b1, 3'd0, 5'd0, 32'd0, 5'd10, 5'd10, g);
        chk("bypass_held", g, 32'hCAFE_0001);

        // Randomised traffic on A with occasional reset.
        for (int i = 0; i < 300; i++) begin
            run_a(($urandom_range(0, 99) != 0), 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), g);
        end
        wait_init_a(3'd0, cnt);

        // Reset asserted in the middle of INIT restarts the clear; INIT writes are lost.
        run_a(1'b1, 3'd1, 5'd9, 32'h0000_0099, 5'd9, 5'd9, g);
        run_a(1'b0, 3'd1, 5'd9, 32'h0000_0077, 5'd9, 5'd9, g);
        for (int i = 0; i < 12; i++) run_a(1'b1, 3'd1, 5'd9, 32'h0000_0066, 5'd9, 5'd9, g);
        run_a(1'b0, 3'd1, 5'd9, 32'h0000_0044, 5'd9, 5'd9, g);
        wait_init_a(3'd1, cnt);
        chk("init_len_midreset", cnt, 32);
        run_a(1'b1, 3'd0, 5'd0, 32'd0, 5'd9, 5'd9, g);
        chk("init_write_lost", g, 32'd0);
        ifa.we_mode = 3'd0;

        // Instance B: 16 entries, three read ports.
        run_b(1'b0, 3'd0, 4'd0, 32'd0, 4'd1, 4'd2, 4'd3);
        cnt = 0;
        while (ifb.init_busy && cnt < 100) begin
            run_b(1'b1, 3'd1, 4'd4, 32'hFFFF_0000, 4'd4, 4'd1, 4'd0);
            cnt++;
        end
        chk("b_init_len", cnt, 16);
        for (int i = 1; i < 16; i++) begin
            run_b(1'b1, 3'd1, 4'(i), 32'(i * 32'h11), 4'(i), 4'(i), 4'(16 - i));
        end
        for (int i = 0; i < 300; i++) begin
            run_b(1'b1, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
                  4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
